// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle MIPS-subset control unit.
// State codes, opcode/funct constants, ALU operation codes and the
// select codes driven towards fetch and the register-file write port.
// The optional halt state is only reachable when CTRL_HALT_EN is defined.
package ctrl_pkg;

   // FSM state encoding (also exposed on the debug state output)
   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   // Instruction classes produced by the decoder
   typedef enum logic [3:0] {
      C_R_ALU = 4'd0,
      C_I_ALU = 4'd1,
      C_LW    = 4'd2,
      C_SW    = 4'd3,
      C_BEQ   = 4'd4,
      C_BNE   = 4'd5,
      C_J     = 4'd6,
      C_JAL   = 4'd7,
      C_JR    = 4'd8,
      C_ILL   = 4'd9
   } iclass_t;

   // Opcodes (ir[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes (ir[5:0])
   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_JR  = 6'b001000;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_XOR = 6'b100110;
   localparam logic [5:0] F_NOR = 6'b100111;
   localparam logic [5:0] F_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_NOR = 4'd5;
   localparam logic [3:0] ALU_SLT = 4'd6;
   localparam logic [3:0] ALU_SLL = 4'd7;

   // PC select codes towards the fetch stage
   localparam logic [1:0] PC_S_SEQ = 2'b00;  // PC+4
   localparam logic [1:0] PC_S_REG = 2'b01;  // register A (jr)
   localparam logic [1:0] PC_S_BR  = 2'b10;  // branch target
   localparam logic [1:0] PC_S_JMP = 2'b11;  // jump target

   // Destination register select
   localparam logic [1:0] WR_S_RD  = 2'b00;
   localparam logic [1:0] WR_S_RT  = 2'b01;
   localparam logic [1:0] WR_S_R31 = 2'b10;

   // Register-file write-data select
   localparam logic [1:0] WD_S_ALU = 2'b00;
   localparam logic [1:0] WD_S_MEM = 2'b01;
   localparam logic [1:0] WD_S_PC  = 2'b10;

   // Branch resolution from the class and the ALU zero flag
   function automatic logic branch_taken(input iclass_t cls, input logic zf);
      return ((cls == C_BEQ) && zf) || ((cls == C_BNE) && !zf);
   endfunction

endpackage

// File: rtl/ctrl_fsm_decode.sv
// ctrl_decode: purely combinational decode of opcode/funct into an
// instruction class plus the ALU controls that depend only on the
// instruction. Anything outside the supported subset decodes to C_ILL.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_t    cls,
   output logic [3:0] alu_op,
   output logic       imm_s,
   output logic       alu_b_s,
   output logic       legal
);

   // Opcode/funct table lookup; defaults describe an illegal instruction
   always_comb begin
      cls     = C_ILL;
      alu_op  = ALU_ADD;
      imm_s   = 1'b0;
      alu_b_s = 1'b0;
      unique case (opcode)
         OP_RTYPE: begin
            cls = C_R_ALU;
            unique case (funct)
               F_ADD:   alu_op = ALU_ADD;
               F_SUB:   alu_op = ALU_SUB;
               F_AND:   alu_op = ALU_AND;
               F_OR:    alu_op = ALU_OR;
               F_XOR:   alu_op = ALU_XOR;
               F_NOR:   alu_op = ALU_NOR;
               F_SLT:   alu_op = ALU_SLT;
               F_SLL:   alu_op = ALU_SLL;
               F_JR:    cls    = C_JR;
               default: cls    = C_ILL;
            endcase
         end
         OP_J:   cls = C_J;
         OP_JAL: cls = C_JAL;
         OP_BEQ: begin
            cls    = C_BEQ;
            alu_op = ALU_SUB;
            imm_s  = 1'b1;
         end
         OP_BNE: begin
            cls    = C_BNE;
            alu_op = ALU_SUB;
            imm_s  = 1'b1;
         end
         OP_ADDI: begin
            cls     = C_I_ALU;
            alu_op  = ALU_ADD;
            imm_s   = 1'b1;
            alu_b_s = 1'b1;
         end
         OP_SLTI: begin
            cls     = C_I_ALU;
            alu_op  = ALU_SLT;
            imm_s   = 1'b1;
            alu_b_s = 1'b1;
         end
         OP_ANDI: begin
            cls     = C_I_ALU;
            alu_op  = ALU_AND;
            alu_b_s = 1'b1;
         end
         OP_ORI: begin
            cls     = C_I_ALU;
            alu_op  = ALU_OR;
            alu_b_s = 1'b1;
         end
         OP_XORI: begin
            cls     = C_I_ALU;
            alu_op  = ALU_XOR;
            alu_b_s = 1'b1;
         end
         OP_LW: begin
            cls     = C_LW;
            alu_op  = ALU_ADD;
            imm_s   = 1'b1;
            alu_b_s = 1'b1;
         end
         OP_SW: begin
            cls     = C_SW;
            alu_op  = ALU_ADD;
            imm_s   = 1'b1;
            alu_b_s = 1'b1;
         end
         default: cls = C_ILL;
      endcase
   end

   assign legal = (cls != C_ILL);

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: five-state multi-cycle control unit (IF/ID/EX/MEM/WB) for a
// MIPS-subset datapath. Outputs are Moore-style from state and the latched
// ir, except the branch decision in EX (zf) and the sw strobe in MEM
// (mem_rdy). Optional macro CTRL_HALT_EN: an illegal instruction parks the
// FSM in S_HALT until reset instead of executing as a NOP.
//
// Memory handshake: mem_rdy is only looked at in S_MEM. The access is
// complete on the first rising edge in S_MEM with mem_rdy=1; a store drives
// mem_we during exactly that cycle. Every S_MEM cycle with mem_rdy=0 is a
// wait cycle counted by a saturating 4-bit counter; a wait beyond
// MEM_WAIT_MAX sets the sticky mem_timeout flag (cleared only by rst).
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] inst_code,
   input  logic              zf,
   input  logic              mem_rdy,
   output logic [ADDR_W-1:0] ir,
   output logic [1:0]        pc_s,
   output logic              pc_we,
   output logic              rf_we,
   output logic [1:0]        w_r_s,
   output logic [1:0]        wr_data_s,
   output logic [3:0]        alu_op,
   output logic              alu_b_s,
   output logic              imm_s,
   output logic              mem_we,
   output logic [2:0]        state,
   output logic              illegal,
   output logic              mem_timeout
);

   localparam logic [3:0] WAIT_LIM = 4'(MEM_WAIT_MAX);
   localparam logic [3:0] CNT_SAT  = 4'hF;

   state_t     st;
   state_t     st_nxt;
   logic [3:0] wait_cnt;
   iclass_t    cls;
   logic       legal;
   logic       pc_we_c;
   logic       rf_we_c;
   logic       mem_we_c;
   logic       illegal_c;

   ctrl_decode u_decode (
      .opcode  (ir[31:26]),
      .funct   (ir[5:0]),
      .cls     (cls),
      .alu_op  (alu_op),
      .imm_s   (imm_s),
      .alu_b_s (alu_b_s),
      .legal   (legal)
   );

   assign state = st;

   // State register and instruction latch (ir only loads in S_IF)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= S_IF;
         ir <= '0;
      end else begin
         st <= st_nxt;
         if (st == S_IF) begin
            ir <= inst_code;
         end
      end
   end

   // MEM wait counter (saturating) and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (st == S_MEM) begin
         if (mem_rdy) begin
            wait_cnt <= '0;
         end else begin
            if (wait_cnt >= WAIT_LIM) begin
               mem_timeout <= 1'b1;
            end
            if (wait_cnt != CNT_SAT) begin
               wait_cnt <= wait_cnt + 4'd1;
            end
         end
      end else begin
         wait_cnt <= '0;
      end
   end

   // Next-state logic, strobes and selects from state and decoded class
   always_comb begin
      st_nxt    = st;
      pc_s      = PC_S_SEQ;
      pc_we_c   = 1'b0;
      rf_we_c   = 1'b0;
      mem_we_c  = 1'b0;
      illegal_c = 1'b0;
      // write-port selects follow the instruction class; rf_we qualifies them
      unique case (cls)
         C_I_ALU: begin
            w_r_s     = WR_S_RT;
            wr_data_s = WD_S_ALU;
         end
         C_LW: begin
            w_r_s     = WR_S_RT;
            wr_data_s = WD_S_MEM;
         end
         C_JAL: begin
            w_r_s     = WR_S_R31;
            wr_data_s = WD_S_PC;
         end
         default: begin
            w_r_s     = WR_S_RD;
            wr_data_s = WD_S_ALU;
         end
      endcase

      unique case (st)
         S_IF: begin
            pc_we_c = 1'b1;
            st_nxt  = S_ID;
         end
         S_ID: begin
            unique case (cls)
               C_JR: begin
                  pc_we_c = 1'b1;
                  pc_s    = PC_S_REG;
                  st_nxt  = S_IF;
               end
               C_J: begin
                  pc_we_c = 1'b1;
                  pc_s    = PC_S_JMP;
                  st_nxt  = S_IF;
               end
               C_JAL: begin
                  pc_we_c = 1'b1;
                  pc_s    = PC_S_JMP;
                  rf_we_c = 1'b1;
                  st_nxt  = S_IF;
               end
               C_ILL: begin
                  illegal_c = 1'b1;
`ifdef CTRL_HALT_EN
                  st_nxt    = S_HALT;
`else
                  st_nxt    = S_IF;
`endif
               end
               default: st_nxt = S_EX;
            endcase
         end
         S_EX: begin
            unique case (cls)
               C_BEQ, C_BNE: begin
                  if (branch_taken(cls, zf)) begin
                     pc_we_c = 1'b1;
                     pc_s    = PC_S_BR;
                  end
                  st_nxt = S_IF;
               end
               C_LW, C_SW:       st_nxt = S_MEM;
               C_R_ALU, C_I_ALU: st_nxt = S_WB;
               default:          st_nxt = S_IF;
            endcase
         end
         S_MEM: begin
            if (mem_rdy) begin
               if (cls == C_SW) begin
                  mem_we_c = 1'b1;
                  st_nxt   = S_IF;
               end else begin
                  st_nxt   = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we_c = 1'b1;
            st_nxt  = S_IF;
         end
         S_HALT: begin
`ifdef CTRL_HALT_EN
            st_nxt = S_HALT;
`else
            st_nxt = S_IF;
`endif
         end
         default: st_nxt = S_IF;
      endcase
   end

   // Strobes are forced low while reset is held
   assign pc_we   = pc_we_c   & ~rst;
   assign rf_we   = rf_we_c   & ~rst;
   assign mem_we  = mem_we_c  & ~rst;
   assign illegal = illegal_c & ~rst & legal_n_unused_guard();

   // legality is carried by the class; this keeps the flag tied to decode
   function automatic logic legal_n_unused_guard();
      return ~legal;
   endfunction

endmodule
